pipe_stage_buffer: RTL and testbench

Generic inter-stage pipeline register that replaces the hand-built per-stage buffers (fetch/decode, decode/execute, and so on) with one parametrised block. It carries an opaque data payload and a control-bit field using a valid/ready handshake. It also supports flush (bubble insertion) and an optional 2-entry skid mode that removes the combinational ready path. Control bits, such as write enables, are forced to zero whenever the output is not valid, so a bubble can never commit state.

---
 rtl/pipe_stage_buffer_pkg.sv | 19 +
 rtl/pipe_stage_buffer_if.sv | 28 ++
 rtl/pipe_entry_reg.sv | 49 ++++
 rtl/pipe_stage_buffer.sv | 112 +++++++++++
 tb/tb_pipe_stage_buffer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline definitions: default field widths and control-bit positions used by
// every inter-stage buffer.
package pipe_stage_buffer_pkg;

   localparam int unsigned PSB_DATA_WIDTH  = 32;
   localparam int unsigned PSB_CTRL_WIDTH  = 2;
   localparam int unsigned REG_INDEX_WIDTH = 4;
   localparam int unsigned ALU_OP_WIDTH    = 5;
   localparam int unsigned MUX_SEL_WIDTH   = 2;

   // Control-bit positions inside the ctrl field.
   localparam int unsigned CTRL_MEM_WE = 0;
   localparam int unsigned CTRL_RF_WE  = 1;

   function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Valid/ready handshake bundle between an upstream stage, the buffer and a downstream stage.
interface pipe_stage_buffer_if
   import pipe_stage_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = PSB_DATA_WIDTH,
   parameter int unsigned CTRL_WIDTH = PSB_CTRL_WIDTH
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [CTRL_WIDTH-1:0] in_ctrl;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CTRL_WIDTH-1:0] out_ctrl;
   logic [1:0]            occupancy;

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, occupancy
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, occupancy
   );

endinterface

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus payload and ctrl with load enable and clear.
// Clear wins over load; ctrl reads zero whenever the entry is invalid.
module pipe_entry_reg #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CTRL_WIDTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [CTRL_WIDTH-1:0] ctrl_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CTRL_WIDTH-1:0] ctrl_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [CTRL_WIDTH-1:0] ctrl_q;

   always_comb begin
      valid_d = valid_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         if (load_i) begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
         end
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = valid_q ? ctrl_q : '0;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Parametrised inter-stage pipeline register with flush and optional 2-entry skid mode
// that registers in_ready.
module pipe_stage_buffer
   import pipe_stage_buffer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = PSB_DATA_WIDTH,
   parameter int unsigned CTRL_WIDTH = PSB_CTRL_WIDTH,
   parameter bit          SKID_EN    = 1'b1
) (
   input logic                clk,
   input logic                reset,
   input logic                flush,
   pipe_stage_buffer_if.slave bus
);

   logic                  in_ready;
   logic                  pop, xfer;
   logic                  main_v, main_load, main_clr;
   logic [DATA_WIDTH-1:0] main_data, main_din;
   logic [CTRL_WIDTH-1:0] main_ctrl, main_cin;
   logic                  skid_v, skid_load, skid_clr;
   logic                  main_v_nxt, skid_v_nxt;
   logic [1:0]            occ_q, occ_d;

   assign pop  = main_v & bus.out_ready;
   assign xfer = bus.in_valid & in_ready;

   pipe_entry_reg #(
      .DATA_WIDTH (DATA_WIDTH),
      .CTRL_WIDTH (CTRL_WIDTH)
   ) u_main (
      .clk_i   (clk),
      .rst_ni  (reset),
      .clr_i   (main_clr),
      .load_i  (main_load),
      .data_i  (main_din),
      .ctrl_i  (main_cin),
      .valid_o (main_v),
      .data_o  (main_data),
      .ctrl_o  (main_ctrl)
   );

   if (SKID_EN) begin : g_skid
      logic [DATA_WIDTH-1:0] skid_data;
      logic [CTRL_WIDTH-1:0] skid_ctrl;

      // in_ready comes straight from the skid valid flop, so there is no ready path.
      assign in_ready  = !skid_v;
      assign main_load = skid_v ? pop : (xfer && (!main_v || pop));
      assign main_din  = skid_v ? skid_data : bus.in_data;
      assign main_cin  = skid_v ? skid_ctrl : bus.in_ctrl;
      assign main_clr  = flush || (pop && !main_load);
      assign skid_load = xfer && main_v && !pop;
      assign skid_clr  = flush || (pop && skid_v);

      pipe_entry_reg #(
         .DATA_WIDTH (DATA_WIDTH),
         .CTRL_WIDTH (CTRL_WIDTH)
      ) u_skid (
         .clk_i   (clk),
         .rst_ni  (reset),
         .clr_i   (skid_clr),
         .load_i  (skid_load),
         .data_i  (bus.in_data),
         .ctrl_i  (bus.in_ctrl),
         .valid_o (skid_v),
         .data_o  (skid_data),
         .ctrl_o  (skid_ctrl)
      );
   end else begin : g_no_skid
      assign in_ready  = !main_v || bus.out_ready;
      assign main_load = xfer;
      assign main_din  = bus.in_data;
      assign main_cin  = bus.in_ctrl;
      assign main_clr  = flush || (pop && !xfer);
      assign skid_load = 1'b0;
      assign skid_clr  = 1'b0;
      assign skid_v    = 1'b0;
   end

   // Mirror the entry registers' next-state so occupancy is itself a flop.
   always_comb begin
      main_v_nxt = main_v;
      if (main_clr) begin
         main_v_nxt = 1'b0;
      end else if (main_load) begin
         main_v_nxt = 1'b1;
      end
      skid_v_nxt = skid_v;
      if (skid_clr) begin
         skid_v_nxt = 1'b0;
      end else if (skid_load) begin
         skid_v_nxt = 1'b1;
      end
      occ_d = occ_count(main_v_nxt, skid_v_nxt);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         occ_q <= 2'd0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = main_v;
   assign bus.out_data  = main_data;
   assign bus.out_ctrl  = main_ctrl;
   assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench driving a single-register and a skid instance with identical directed stimulus,
// checked every cycle against a queue model plus literal expectations.
module tb_pipe_stage_buffer;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic [1:0]  in_ctrl;
   logic        out_ready;

   int checks;
   int errors;

   // Model: per instance an ordered list of held entries (k=0 single, k=1 skid).
   logic [31:0] md [2][2];
   logic [1:0]  mc [2][2];
   int          mn [2];

   pipe_stage_buffer_if #(.DATA_WIDTH(32), .CTRL_WIDTH(2)) if0 ();
   pipe_stage_buffer_if #(.DATA_WIDTH(32), .CTRL_WIDTH(2)) if1 ();

   assign if0.in_valid  = in_valid;
   assign if0.in_data   = in_data;
   assign if0.in_ctrl   = in_ctrl;
   assign if0.out_ready = out_ready;
   assign if1.in_valid  = in_valid;
   assign if1.in_data   = in_data;
   assign if1.in_ctrl   = in_ctrl;
   assign if1.out_ready = out_ready;

   pipe_stage_buffer #(.DATA_WIDTH(32), .CTRL_WIDTH(2), .SKID_EN(1'b0)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (if0)
   );

   pipe_stage_buffer #(.DATA_WIDTH(32), .CTRL_WIDTH(2), .SKID_EN(1'b1)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_ready(input int k);
      if (k == 1) return (mn[k] < 2);
      return (mn[k] == 0) || out_ready;
   endfunction

   function automatic logic        act_valid(input int k);
      return (k == 0) ? if0.out_valid : if1.out_valid;
   endfunction
   function automatic logic        act_ready(input int k);
      return (k == 0) ? if0.in_ready : if1.in_ready;
   endfunction
   function automatic logic [31:0] act_data(input int k);
      return (k == 0) ? if0.out_data : if1.out_data;
   endfunction
   function automatic logic [1:0]  act_ctrl(input int k);
      return (k == 0) ? if0.out_ctrl : if1.out_ctrl;
   endfunction
   function automatic logic [1:0]  act_occ(input int k);
      return (k == 0) ? if0.occupancy : if1.occupancy;
   endfunction

   task automatic compare_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("s%0d.out_valid", k), 32'(act_valid(k)), 32'(mn[k] > 0));
         chk($sformatf("s%0d.in_ready", k), 32'(act_ready(k)), 32'(exp_ready(k)));
         chk($sformatf("s%0d.occupancy", k), 32'(act_occ(k)), 32'(mn[k]));
         chk($sformatf("s%0d.out_ctrl", k), 32'(act_ctrl(k)),
             (mn[k] > 0) ? 32'(mc[k][0]) : 32'd0);
         if (mn[k] > 0) chk($sformatf("s%0d.out_data", k), act_data(k), md[k][0]);
      end
   endtask

   task automatic model_step();
      logic acc;
      for (int k = 0; k < 2; k++) begin
         if (flush) begin
            mn[k] = 0;
         end else begin
            acc = in_valid && exp_ready(k);
            if (mn[k] > 0 && out_ready) begin
               md[k][0] = md[k][1];
               mc[k][0] = mc[k][1];
               mn[k]--;
            end
            if (acc && mn[k] < 2) begin
               md[k][mn[k]] = in_data;
               mc[k][mn[k]] = in_ctrl;
               mn[k]++;
            end
         end
      end
   endtask

   // Compare on the falling edge, then advance the model on the rising edge.
   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      if (reset) model_step();
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".s0.out_valid"}, 32'(if0.out_valid), 32'd0);
      chk({tag, ".s1.out_valid"}, 32'(if1.out_valid), 32'd0);
      chk({tag, ".s0.out_ctrl"}, 32'(if0.out_ctrl), 32'd0);
      chk({tag, ".s1.out_ctrl"}, 32'(if1.out_ctrl), 32'd0);
      chk({tag, ".s0.occ"}, 32'(if0.occupancy), 32'd0);
      chk({tag, ".s1.occ"}, 32'(if1.occupancy), 32'd0);
      chk({tag, ".s0.in_ready"}, 32'(if0.in_ready), 32'd1);
      chk({tag, ".s1.in_ready"}, 32'(if1.in_ready), 32'd1);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      mn[0]     = 0;
      mn[1]     = 0;
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      in_ctrl   = 2'b00;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset state
      chk_idle("reset");
      chk("reset.s0.out_data", if0.out_data, 32'd0);
      chk("reset.s1.out_data", if1.out_data, 32'd0);

      // Single push, 1-cycle latency
      in_valid = 1'b1; in_data = 32'h0000_1234; in_ctrl = 2'b11; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk("t1.s0.out_data", if0.out_data, 32'h1234);
      chk("t1.s1.out_data", if1.out_data, 32'h1234);
      chk("t1.s0.out_ctrl", 32'(if0.out_ctrl), 32'd3);
      chk("t1.s1.out_ctrl", 32'(if1.out_ctrl), 32'd3);
      cycle();
      // Ctrl masked once the entry has popped
      chk_idle("t5");

      // Backpressure fills the skid instance
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hA; in_ctrl = 2'b01;
      cycle();
      in_data = 32'hB; in_ctrl = 2'b10;
      cycle();
      in_valid = 1'b0;
      chk("t2.s1.occ", 32'(if1.occupancy), 32'd2);
      chk("t2.s1.in_ready", 32'(if1.in_ready), 32'd0);
      chk("t2.s1.out_data", if1.out_data, 32'hA);
      chk("t2.s0.occ", 32'(if0.occupancy), 32'd1);
      out_ready = 1'b1;
      cycle();
      chk("t2.s1.pop1_data", if1.out_data, 32'hB);
      chk("t2.s1.pop1_ready", 32'(if1.in_ready), 32'd1);
      chk("t2.s1.pop1_occ", 32'(if1.occupancy), 32'd1);
      cycle();
      chk_idle("t2.end");

      // Streaming at full rate
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 32'(i); in_ctrl = 2'(i);
         cycle();
         chk($sformatf("t3.s0.data%0d", i), if0.out_data, 32'(i));
         chk($sformatf("t3.s1.data%0d", i), if1.out_data, 32'(i));
         chk($sformatf("t3.s1.valid%0d", i), 32'(if1.out_valid), 32'd1);
      end
      in_valid = 1'b0;
      cycle();

      // Flush while full discards the concurrent offer
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1; in_ctrl = 2'b11;
      cycle();
      in_data = 32'h2;
      cycle();
      chk("t4.s1.full", 32'(if1.occupancy), 32'd2);
      flush = 1'b1; in_data = 32'hC;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      chk_idle("t4");
      out_ready = 1'b1;
      repeat (3) cycle();

      // Asynchronous reset between edges while full
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h5; in_ctrl = 2'b11;
      cycle();
      in_data = 32'h6;
      cycle();
      chk("t6.s1.full", 32'(if1.occupancy), 32'd2);
      #2;
      reset = 1'b0;
      mn[0] = 0;
      mn[1] = 0;
      #1;
      chk_idle("t6");
      chk("t6.s0.out_data", if0.out_data, 32'd0);
      chk("t6.s1.out_data", if1.out_data, 32'd0);
      in_valid = 1'b0;
      repeat (2) cycle();
      reset = 1'b1;
      repeat (2) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
